dmem_dma_arbiter: RTL and testbench
===================================

# dmem_dma_arbiter

Shares the single-port data memory between the MIPS core and a word-copy DMA engine. The CPU always has priority and never stalls; the DMA engine uses only cycles in which the CPU makes no data-memory access. The block sits between the core's data-memory signals and `dmem`. It is configured by a start pulse with source, destination and length.

## Interface

**Parameters**
- `AW`, 6: word-address width (64-word `dmem`).
- `DW`, 32: data width.

**Ports**
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `cpu_we` input 1: CPU store this cycle.
- `cpu_re` input 1: CPU load this cycle.
- `cpu_a` input AW: CPU word address.
- `cpu_wd` input DW: CPU store data.
- `cpu_rd` output DW: load data returned to the CPU.
- `dma_start` input 1: start pulse; sampled only in IDLE.
- `dma_src` input AW: first source word address.
- `dma_dst` input AW: first destination word address.
- `dma_len` input AW+1: word count, 0..2^AW.
- `dma_busy` output 1: a transfer is in progress.
- `dma_done` output 1: one-cycle completion pulse.
- `dma_stall_cnt` output 16: count of DMA stall cycles (see Configuration).
- `mem_we` output 1: `dmem` write enable.
- `mem_a` output AW: `dmem` word address.
- `mem_d` output DW: `dmem` write data.
- `mem_q` input DW: `dmem` asynchronous read data.

## Operation

**Grant**
- Define `cpu_req = cpu_we | cpu_re`.
- When `cpu_req` is high: `mem_a = cpu_a`, `mem_we = cpu_we`, `mem_d = cpu_wd`. This path is purely combinational.
- `cpu_rd = mem_q` at all times.
- The DMA engine is granted in a cycle only when `cpu_req = 0` and its state is RD or WR.

**State machine: IDLE, RD, WR, DONE**
- **IDLE**
  - On `dma_start`, latch `src`, `dst` and `rem = dma_len`.
  - If `dma_len = 0`, go to DONE; otherwise go to RD.
- **RD**
  - If granted: `mem_a = src`, capture `mem_q` into the buffer, then go to WR.
  - If not granted: hold state.
- **WR**
  - If granted: `mem_a = dst`, `mem_we = 1`, `mem_d = buffer`.
  - Then `src += 1` and `dst += 1`, both modulo 2^AW (addresses wrap at 63 → 0), and `rem -= 1`.
  - If the new `rem` is 0, go to DONE; otherwise go to RD.
  - If not granted: hold state.
- **DONE**
  - `dma_done = 1` for this one cycle, then go to IDLE.

**Outputs and boundary rules**
- `dma_busy` is high in RD and WR only.
- `dma_start` is ignored outside IDLE. Configuration inputs are ignored outside IDLE.
- When the DMA engine is not granted and `cpu_req = 0`, drive `mem_we = 0`, `mem_a = 0`, `mem_d = 0`.
- Overlapping regions are copied word by word in ascending order. With `dst > src` and overlap, source words are overwritten before they are read; this is the defined behaviour.
- A CPU store to a word the DMA engine has already buffered does not update the buffer. The old value is written.

## Timing

- **Reset values:** state IDLE; `dma_busy = 0`, `dma_done = 0`, `mem_we = 0`, `dma_stall_cnt = 0`; internal `src`, `dst`, `rem` and buffer all 0.
- **Reset mid-transfer:** return to IDLE with no further write. Words already written stay written.
- **Start timing:** `dma_start` is sampled at edge T. The first RD cycle is T+1.
- **Uncontended transfer:** N words take 2N cycles. `dma_done` is high in cycle T+2N+1, and `dma_busy` is low in that cycle.
- **Zero length:** with `dma_len = 0`, `dma_done` is high in cycle T+1. No memory access occurs.
- **Contention:** each cycle with `cpu_req = 1` in RD or WR adds exactly one cycle of latency.
- **CPU latency:** zero added latency, combinational through the block.

## Configuration

`DMEM_DMA_STATS_EN`:
- **Defined:** `dma_stall_cnt` increments each cycle the state is RD or WR and `cpu_req = 1`. It saturates at 0xFFFF. It clears on `rst` and on an accepted `dma_start`.
- **Undefined:** `dma_stall_cnt` is tied to 0 and no counter logic is built.

## Structure

- **Package `dmem_dma_pkg`:**
  - state enum (IDLE, RD, WR, DONE);
  - default `AW` and `DW` constants;
  - stall-counter width constant (16).
- **Sub-module:** one, `sat_counter`, a saturating counter with clear and enable. It is instantiated only under `DMEM_DMA_STATS_EN`.

## Test plan

- **Reset:** hold `rst` 2 cycles mid-transfer. State is IDLE, `dma_busy = 0`, and no `mem_we` occurs afterward.
- **Uncontended copy:** preload words 0..3 with 0xA0..0xA3; start `src = 0`, `dst = 8`, `len = 4`, with `cpu_req = 0`. Words 8..11 equal 0xA0..0xA3, and `dma_done` pulses exactly 9 cycles after the start edge.
- **Contention:** same copy with `cpu_re = 1` held for 3 cycles during the transfer. CPU reads return correct data, `dma_done` arrives 3 cycles later, and with the macro defined `dma_stall_cnt = 3`.
- **Wrap-around:** `src = 62`, `dst = 30`, `len = 4`. Words 30..33 receive the contents of 62, 63, 0, 1.
- **Edge cases:**
  - `len = 0` → `dma_done` at T+1 with no `mem_we`.
  - `dma_start` asserted while busy → ignored; original transfer completes unchanged.
- **Stall-count saturation (macro defined):** hold `cpu_req = 1` for 70000 cycles during a transfer. `dma_stall_cnt` reaches 0xFFFF and holds.

Source files
------------

// File: rtl/dmem_dma_pkg.sv
// Shared types and constants for the data-memory / DMA arbiter.
package dmem_dma_pkg;

    localparam int unsigned DMEM_AW = 6;
    localparam int unsigned DMEM_DW = 32;
    localparam int unsigned STALL_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } dma_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and enable.
module sat_counter
    import dmem_dma_pkg::*;
#(
    parameter int unsigned W = STALL_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/dmem_dma_arbiter.sv
// Single-port dmem arbiter: CPU has absolute priority, word-copy DMA uses idle cycles.
// Optional stall statistics are built only when DMEM_DMA_STATS_EN is defined.
module dmem_dma_arbiter
    import dmem_dma_pkg::*;
#(
    parameter int unsigned AW = DMEM_AW,
    parameter int unsigned DW = DMEM_DW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cpu_we,
    input  logic               cpu_re,
    input  logic [AW-1:0]      cpu_a,
    input  logic [DW-1:0]      cpu_wd,
    output logic [DW-1:0]      cpu_rd,
    input  logic               dma_start,
    input  logic [AW-1:0]      dma_src,
    input  logic [AW-1:0]      dma_dst,
    input  logic [AW:0]        dma_len,
    output logic               dma_busy,
    output logic               dma_done,
    output logic [STALL_W-1:0] dma_stall_cnt,
    output logic               mem_we,
    output logic [AW-1:0]      mem_a,
    output logic [DW-1:0]      mem_d,
    input  logic [DW-1:0]      mem_q
);

    dma_state_t    state;
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    logic [AW:0]   rem;
    logic [DW-1:0] data_buf;

    logic cpu_req;
    logic dma_active;
    logic dma_gnt;

    assign cpu_req    = cpu_we | cpu_re;
    assign dma_active = (state == ST_RD) || (state == ST_WR);
    assign dma_gnt    = dma_active && !cpu_req;
    assign cpu_rd     = mem_q;

    // Memory port mux: CPU path is purely combinational, DMA fills the gaps.
    always_comb begin
        mem_we = 1'b0;
        mem_a  = '0;
        mem_d  = '0;
        if (cpu_req) begin
            mem_we = cpu_we;
            mem_a  = cpu_a;
            mem_d  = cpu_wd;
        end else if (dma_gnt) begin
            if (state == ST_RD) begin
                mem_a = src;
            end else begin
                mem_we = 1'b1;
                mem_a  = dst;
                mem_d  = data_buf;
            end
        end
    end

    // DMA sequencer with registered busy/done flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            src      <= '0;
            dst      <= '0;
            rem      <= '0;
            data_buf <= '0;
            dma_busy <= 1'b0;
            dma_done <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    dma_done <= 1'b0;
                    if (dma_start) begin
                        src <= dma_src;
                        dst <= dma_dst;
                        rem <= dma_len;
                        if (dma_len == '0) begin
                            state    <= ST_DONE;
                            dma_done <= 1'b1;
                        end else begin
                            state    <= ST_RD;
                            dma_busy <= 1'b1;
                        end
                    end
                end
                ST_RD: begin
                    if (dma_gnt) begin
                        data_buf <= mem_q;
                        state    <= ST_WR;
                    end
                end
                ST_WR: begin
                    if (dma_gnt) begin
                        src <= src + AW'(1);
                        dst <= dst + AW'(1);
                        rem <= rem - (AW+1)'(1);
                        if (rem == (AW+1)'(1)) begin
                            state    <= ST_DONE;
                            dma_busy <= 1'b0;
                            dma_done <= 1'b1;
                        end else begin
                            state <= ST_RD;
                        end
                    end
                end
                ST_DONE: begin
                    state    <= ST_IDLE;
                    dma_done <= 1'b0;
                end
                default: begin
                    state    <= ST_IDLE;
                    dma_busy <= 1'b0;
                    dma_done <= 1'b0;
                end
            endcase
        end
    end

`ifdef DMEM_DMA_STATS_EN
    logic stall_clr;
    logic stall_en;

    // Counter restarts on every accepted start so it reflects the current transfer.
    assign stall_clr = (state == ST_IDLE) && dma_start;
    assign stall_en  = dma_active && cpu_req;

    sat_counter #(
        .W (STALL_W)
    ) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .clr (stall_clr),
        .en  (stall_en),
        .cnt (dma_stall_cnt)
    );
`else
    assign dma_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_dmem_dma_arbiter.sv
// Self-checking bench for dmem_dma_arbiter with a behavioural dmem and copy model.
module tb_dmem_dma_arbiter;
    import dmem_dma_pkg::*;

    localparam int unsigned AW    = 6;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 64;

    logic               clk = 1'b0;
    logic               rst;
    logic               cpu_we, cpu_re;
    logic [AW-1:0]      cpu_a;
    logic [DW-1:0]      cpu_wd, cpu_rd;
    logic               dma_start;
    logic [AW-1:0]      dma_src, dma_dst;
    logic [AW:0]        dma_len;
    logic               dma_busy, dma_done;
    logic [STALL_W-1:0] dma_stall_cnt;
    logic               mem_we;
    logic [AW-1:0]      mem_a;
    logic [DW-1:0]      mem_d, mem_q;

    logic [DW-1:0] dmem  [DEPTH];
    logic [DW-1:0] model [DEPTH];

    int checks = 0;
    int errors = 0;

    dmem_dma_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk           (clk),
        .rst           (rst),
        .cpu_we        (cpu_we),
        .cpu_re        (cpu_re),
        .cpu_a         (cpu_a),
        .cpu_wd        (cpu_wd),
        .cpu_rd        (cpu_rd),
        .dma_start     (dma_start),
        .dma_src       (dma_src),
        .dma_dst       (dma_dst),
        .dma_len       (dma_len),
        .dma_busy      (dma_busy),
        .dma_done      (dma_done),
        .dma_stall_cnt (dma_stall_cnt),
        .mem_we        (mem_we),
        .mem_a         (mem_a),
        .mem_d         (mem_d),
        .mem_q         (mem_q)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) dmem[mem_a] <= mem_d;
    end
    assign mem_q = dmem[mem_a];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        cpu_we = 1'b0; cpu_re = 1'b0; cpu_a = '0; cpu_wd = '0;
        dma_start = 1'b0; dma_src = '0; dma_dst = '0; dma_len = '0;
    endtask

    task automatic cpu_store(input int a, input logic [DW-1:0] d);
        cpu_we = 1'b1; cpu_a = AW'(a); cpu_wd = d;
        tick();
        cpu_we = 1'b0;
        model[a] = d;
    endtask

    task automatic compare_mem(input string tag);
        for (int i = 0; i < int'(DEPTH); i++) begin
            check($sformatf("%s_word%0d", tag, i), 64'(dmem[i]), 64'(model[i]));
        end
    endtask

    // Expected stall count depends on whether statistics are built.
    function automatic logic [63:0] exp_stalls(input int s);
`ifdef DMEM_DMA_STATS_EN
        return 64'(s > 65535 ? 65535 : s);
`else
        return 64'(s - s);
`endif
    endfunction

    // cpu_mode: 0 idle, 1 random CPU traffic, 2 three leading CPU reads.
    task automatic run_copy(input string tag, input int src, input int dst, input int len,
                            input int cpu_mode, input bit poke_start);
        int remaining, elapsed, stalls, ca;
        bit did_cpu, is_wr;
        logic [DW-1:0] wd;
        dma_src = AW'(src); dma_dst = AW'(dst); dma_len = (AW+1)'(len);
        dma_start = 1'b1;
        tick();
        dma_start = 1'b0;
        for (int i = 0; i < len; i++) model[(dst + i) % DEPTH] = model[(src + i) % DEPTH];
        remaining = 2 * len;
        elapsed   = 1;
        stalls    = 0;
        while (remaining > 0) begin
            did_cpu = 1'b0;
            is_wr   = 1'b0;
            if ((cpu_mode == 2 && stalls < 3) || (cpu_mode == 1 && $urandom_range(0, 2) == 0)) begin
                did_cpu = 1'b1;
                is_wr   = (cpu_mode == 1) && ($urandom_range(0, 1) == 1);
                ca      = int'($urandom_range(48, 63));
                wd      = $urandom;
                cpu_a   = AW'(ca);
                cpu_wd  = wd;
                cpu_we  = is_wr;
                cpu_re  = !is_wr;
                stalls++;
            end else begin
                remaining--;
            end
            if (poke_start && elapsed == 2) begin
                dma_start = 1'b1; dma_src = 6'd40; dma_dst = 6'd44; dma_len = 7'd2;
            end
            @(negedge clk);
            check({tag, "_busy"}, 64'(dma_busy), 64'd1);
            check({tag, "_done_early"}, 64'(dma_done), 64'd0);
            if (did_cpu) begin
                check({tag, "_cpu_addr"}, 64'(mem_a), 64'(ca));
                check({tag, "_cpu_we"}, 64'(mem_we), 64'(is_wr));
                if (!is_wr) check({tag, "_cpu_rd"}, 64'(cpu_rd), 64'(model[ca]));
            end
            tick();
            if (did_cpu && is_wr) model[ca] = wd;
            cpu_we = 1'b0; cpu_re = 1'b0; dma_start = 1'b0;
            elapsed++;
        end
        @(negedge clk);
        check({tag, "_done"}, 64'(dma_done), 64'd1);
        check({tag, "_busy_at_done"}, 64'(dma_busy), 64'd0);
        if (len == 0) check({tag, "_no_we"}, 64'(mem_we), 64'd0);
        check({tag, "_stalls"}, 64'(dma_stall_cnt), exp_stalls(stalls));
        tick();
        check({tag, "_done_pulse"}, 64'(dma_done), 64'd0);
        compare_mem(tag);
    endtask

    initial begin
        int s, d, n;
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", 64'(dma_busy), 64'd0);
        check("rst_done", 64'(dma_done), 64'd0);
        check("rst_mem_we", 64'(mem_we), 64'd0);
        check("rst_mem_a", 64'(mem_a), 64'd0);
        check("rst_mem_d", 64'(mem_d), 64'd0);
        check("rst_stall", 64'(dma_stall_cnt), 64'd0);
        tick();

        for (int i = 0; i < int'(DEPTH); i++) cpu_store(i, $urandom);
        for (int i = 0; i < 4; i++) cpu_store(i, DW'(32'hA0 + i));
        compare_mem("preload");

        run_copy("plain", 0, 8, 4, 0, 1'b0);
        run_copy("contend", 0, 8, 4, 2, 1'b0);
        run_copy("wrap", 62, 30, 4, 0, 1'b0);
        run_copy("zero", 5, 20, 0, 0, 1'b0);
        run_copy("busy_start", 10, 20, 5, 0, 1'b1);
        run_copy("overlap_up", 2, 4, 6, 0, 1'b0);

        for (int k = 0; k < 6; k++) begin
            n = int'($urandom_range(1, 16));
            s = int'($urandom_range(0, 48 - n));
            d = int'($urandom_range(0, 48 - n));
            run_copy($sformatf("rand%0d", k), s, d, n, 1, 1'b0);
        end

        // Reset mid-transfer: two words copied, then nothing further.
        dma_src = 6'd0; dma_dst = 6'd16; dma_len = 7'd8; dma_start = 1'b1;
        tick();
        dma_start = 1'b0;
        for (int i = 0; i < 2; i++) model[16 + i] = model[i];
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("midrst_busy", 64'(dma_busy), 64'd0);
        check("midrst_done", 64'(dma_done), 64'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("midrst_no_we", 64'(mem_we), 64'd0);
            tick();
        end
        compare_mem("midrst");

`ifdef DMEM_DMA_STATS_EN
        // Long CPU hog to saturate the stall counter.
        dma_src = 6'd1; dma_dst = 6'd12; dma_len = 7'd1; dma_start = 1'b1;
        tick();
        dma_start = 1'b0;
        model[12] = model[1];
        cpu_re = 1'b1; cpu_a = 6'd50;
        for (int i = 0; i < 70000; i++) tick();
        @(negedge clk);
        check("sat_cnt", 64'(dma_stall_cnt), 64'hFFFF);
        check("sat_busy", 64'(dma_busy), 64'd1);
        tick();
        cpu_re = 1'b0;
        tick();
        tick();
        @(negedge clk);
        check("sat_done", 64'(dma_done), 64'd1);
        check("sat_cnt_hold", 64'(dma_stall_cnt), 64'hFFFF);
        tick();
        compare_mem("sat");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
